// File: rtl/addsub_seq.sv
// addsub_seq: chunk-serial adder/subtractor.
// Operands of WIDTH*WORDS bits arrive as WORDS chunks of WIDTH bits,
// least-significant chunk first. The carry/borrow between chunks is kept in a
// register, so the combinational carry chain is only WIDTH bits long.
// Optional feature: define ADDSUB_OVF_EN to add the signed-overflow output ovf.
module addsub_seq #(
  parameter int WIDTH = 4,
  parameter int WORDS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             s_valid,
  output logic             done,
  output logic             cout,
  output logic             busy
`ifdef ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Chunk counter needs at least one bit even when WORDS == 1.
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_sub;      // mode captured at start
  logic             r_cr;       // carry (add) or inverted borrow (sub) between chunks
  logic [CW-1:0]    r_cnt;      // index of the next chunk to accept

  logic [WIDTH-1:0] r_s;
  logic             r_s_valid;
  logic             r_done;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_t;

`ifdef ADDSUB_OVF_EN
  logic             r_ovf;
  logic             w_c_msb_in;
  logic             w_ovf;
`endif

  // A chunk is taken only while running; the final chunk ends the operation.
  assign w_accept = in_valid && (r_state == ST_RUN);
  assign w_last   = (r_cnt == LAST_CNT);

  // Subtraction is A + ~B + cr, where cr starts as the inverted borrow-in.
  assign w_b_eff  = r_sub ? ~b : b;
  assign w_t      = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, r_cr};

`ifdef ADDSUB_OVF_EN
  // The carry into the MSB is recovered from the MSB sum bit; on the last chunk
  // the MSB of the chunk is the sign bit of the full-width result.
  assign w_c_msb_in = a[WIDTH-1] ^ w_b_eff[WIDTH-1] ^ w_t[WIDTH-1];
  assign w_ovf      = w_c_msb_in ^ w_t[WIDTH];
`endif

  // Next-state decode: IDLE waits for start, RUN leaves after the last accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation context: mode, inter-chunk carry and chunk counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
      r_cr  <= 1'b0;
      r_cnt <= {CW{1'b0}};
    end else if ((r_state == ST_IDLE) && start) begin
      r_sub <= sub;
      r_cr  <= sub ? ~cin : cin;
      r_cnt <= {CW{1'b0}};
    end else if (w_accept) begin
      r_cr  <= w_t[WIDTH];
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result chunk and its valid pulse; s holds between accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s       <= {WIDTH{1'b0}};
      r_s_valid <= 1'b0;
    end else begin
      r_s_valid <= w_accept;
      if (w_accept) begin
        r_s <= w_t[WIDTH-1:0];
      end
    end
  end

  // Completion pulse and final carry/borrow, held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_done <= w_accept && w_last;
      if (w_accept && w_last) begin
        r_cout <= r_sub ? ~w_t[WIDTH] : w_t[WIDTH];
      end
    end
  end

`ifdef ADDSUB_OVF_EN
  // Signed overflow of the full result, captured on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_last) begin
      r_ovf <= w_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign s        = r_s;
  assign s_valid  = r_s_valid;
  assign done     = r_done;
  assign cout     = r_cout;
  // Handshake and status come straight from the state flop.
  assign in_ready = (r_state == ST_RUN);
  assign busy     = (r_state == ST_RUN);

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Parametrised sequential adder/subtractor: the multi-cycle successor to the team's 4-bit combinational ripple adder on the CoolRunner-II fabric. It processes operands of WIDTH*WORDS bits as WORDS chunks of WIDTH bits, least-significant chunk first. Carry/borrow is held in a register between chunks, so the combinational carry chain stays WIDTH bits long regardless of total operand size. It sits between a chunk-serial operand source and a result sink.

## Interface
- WIDTH, 4, chunk width in bits (>= 1)
- WORDS, 2, chunks per operation (>= 1); total operand width is WIDTH*WORDS

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begins an operation; sampled only in IDLE
- sub  in  1  mode, sampled with start: 0 = A+B+cin, 1 = A-B-cin
- cin  in  1  carry-in (add) or borrow-in (sub), sampled with start
- in_valid  in  1  chunk a/b present
- in_ready  out  1  block accepts a chunk; high only in RUN
- a  in  WIDTH  operand A chunk
- b  in  WIDTH  operand B chunk
- s  out  WIDTH  registered result chunk
- s_valid  out  1  one-cycle pulse, s valid
- done  out  1  one-cycle pulse with the last s_valid
- cout  out  1  final carry-out (add) or borrow-out (sub)
- busy  out  1  high in RUN
- ovf  out  1  signed overflow; present only with ADDSUB_OVF_EN

## Operation
- States:
  - IDLE: in_ready=0, busy=0.
  - RUN: in_ready=1, busy=1.
- IDLE -> RUN when start=1. This captures sub, loads the carry register cr = sub ? ~cin : cin, and clears the chunk counter.
- RUN: an accept is a cycle with in_valid && in_ready.
  - Add: t = a + b + cr.
  - Sub: t = a + ~b + cr.
  - t is WIDTH+1 bits wide.
  - s <= t[WIDTH-1:0], cr <= t[WIDTH], s_valid <= 1, counter++.
- Accept with counter == WORDS-1 (the last chunk):
  - done <= 1.
  - cout <= sub ? ~t[WIDTH] : t[WIDTH].
  - State -> IDLE.
- Sub mode: cout=1 means unsigned A < B + cin, i.e. a borrow.
- in_valid low in RUN stalls; cr, counter and s are held.
- Ignored inputs:
  - start in RUN.
  - in_valid in IDLE.
  - a and b when not accepted.
- cout, s (and ovf) hold their values until overwritten by the next operation. s_valid and done are single-cycle pulses.
- WORDS=1: one accept completes the operation.
- Counter width is max(1, clog2(WORDS)).

## Timing
- Reset values:
  - State IDLE, cr=0, counter=0.
  - s=0, s_valid=0, done=0, cout=0, busy=0, in_ready=0, ovf=0.
- Reset asserted mid-operation aborts immediately. Partial results are discarded and no done pulse is issued.
- Latency:
  - start at cycle n -> in_ready=1 at cycle n+1.
  - Accept at cycle k -> s and s_valid at cycle k+1.
- Throughput: one chunk per cycle.
- Minimum operation: 1 + WORDS cycles from start to the final s_valid.
- start may be asserted in the same cycle that done is high, since the state is already IDLE. in_ready then rises the following cycle.
- All outputs are registered. in_ready and busy are decoded from state flops only.

## Configuration
- ADDSUB_OVF_EN defined:
  - Port ovf exists.
  - On the last accept, ovf <= carry-into-MSB XOR raw carry-out-of-MSB (t[WIDTH] before the sub inversion). This is two's-complement overflow of the full WIDTH*WORDS-bit result.
  - ovf is valid with done and held until the next done.
- ADDSUB_OVF_EN undefined: no ovf port and no overflow logic.

## Test plan
WIDTH=4, WORDS=2 throughout.
- Add 0x3C + 0x45, cin=0, back-to-back chunks -> s=0x1 then s=0x8 on consecutive cycles; done with the second; cout=0.
- Sub 0x50 - 0x21, cin=1 -> s=0xE then s=0x2; cout=0. Then sub 0x10 - 0x20, cin=0 -> s=0x0 then 0xF; cout=1.
- Add 0xFF + 0x01 -> s=0x0, 0x0; cout=1; ovf=0. Add 0x7F + 0x01 -> s=0x0, 0x8; cout=0; ovf=1 (only with ADDSUB_OVF_EN).
- Stall: add 0x0F + 0x01 with in_valid low for 3 cycles between chunks -> carry is held; s=0x0 then 0x1; cout=0.
- Reset and ignored inputs:
  - Assert rst_n=0 after the first accept -> all outputs return to reset values; no done pulse.
  - start during RUN -> ignored.
  - in_valid in IDLE -> no s_valid.
